// File: rtl/ci_dsp_pkg.sv
// Shared types and default geometry for the CI frame sequencer and its peak trackers.
package ci_dsp_pkg;
  localparam int N_DEF     = 64;
  localparam int W_DEF     = 12;
  localparam int BIN_W_DEF = 6;
  localparam int OVR_W_DEF = 8;

  localparam int B730_LO = 5;
  localparam int B730_HI = 7;
  localparam int B850_LO = 10;
  localparam int B850_HI = 12;

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_FFT, REPORT} seq_state_t;
endpackage

// File: rtl/ci_frame_sequencer_if.sv
// Reader / FFT / uController signal bundle around the frame sequencer.
interface ci_frame_sequencer_if
  import ci_dsp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BIN_W = BIN_W_DEF,
  parameter int OVR_W = OVR_W_DEF
);
  logic             enable;
  logic             sample_rdy;
  logic [W-1:0]     sample;
  logic             fft_in_valid;
  logic [W-1:0]     fft_in_data;
  logic             fft_in_last;
  logic             fft_out_valid;
  logic [BIN_W-1:0] fft_out_bin;
  logic [W-1:0]     fft_out_mag;
  logic             fft_out_last;
  logic             res_valid;
  logic             res_ack;
  logic [W-1:0]     max730;
  logic [W-1:0]     max850;
  logic [BIN_W-1:0] bin730;
  logic [BIN_W-1:0] bin850;
  logic [OVR_W-1:0] overrun_cnt;

  modport master (
    output enable, sample_rdy, sample, fft_out_valid, fft_out_bin, fft_out_mag, fft_out_last, res_ack,
    input  fft_in_valid, fft_in_data, fft_in_last, res_valid, max730, max850, bin730, bin850, overrun_cnt
  );

  modport slave (
    input  enable, sample_rdy, sample, fft_out_valid, fft_out_bin, fft_out_mag, fft_out_last, res_ack,
    output fft_in_valid, fft_in_data, fft_in_last, res_valid, max730, max850, bin730, bin850, overrun_cnt
  );
endinterface

// File: rtl/ci_peak_tracker.sv
// Registered peak-magnitude search over one inclusive bin window; strict compare keeps the earliest bin on ties.
module ci_peak_tracker
  import ci_dsp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BIN_W = BIN_W_DEF,
  parameter int LO    = B730_LO,
  parameter int HI    = B730_HI
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [BIN_W-1:0] bin,
  input  logic [W-1:0]     mag,
  output logic [W-1:0]     peak,
  output logic [BIN_W-1:0] peak_bin
);
  logic in_win;
  assign in_win = (bin >= BIN_W'(LO)) && (bin <= BIN_W'(HI));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak     <= '0;
      peak_bin <= '0;
    end else if (valid && in_win && (mag > peak)) begin
      peak     <= mag;
      peak_bin <= bin;
    end
  end
endmodule

// File: rtl/ci_frame_sequencer.sv
// Gates N-sample frames into the FFT, tracks 730/850 nm window peaks and reports them with valid/ack.
module ci_frame_sequencer
  import ci_dsp_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int BIN_W   = BIN_W_DEF,
  parameter int B730_LO = ci_dsp_pkg::B730_LO,
  parameter int B730_HI = ci_dsp_pkg::B730_HI,
  parameter int B850_LO = ci_dsp_pkg::B850_LO,
  parameter int B850_HI = ci_dsp_pkg::B850_HI,
  parameter int OVR_W   = OVR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ci_frame_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(N);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             trk_valid;
  logic             trk_clear;
  logic             busy;

  // Peaks only move while the FFT result is expected; they reset as the FSM drops back to IDLE.
  assign trk_valid = bus.fft_out_valid && (state == WAIT_FFT);
  assign trk_clear = (state == REPORT) && bus.res_ack;
  assign busy      = (state == WAIT_FFT) || (state == REPORT);

  ci_peak_tracker #(.W(W), .BIN_W(BIN_W), .LO(B730_LO), .HI(B730_HI)) u_pk730 (
    .clk(clk), .rst(rst), .clear(trk_clear), .valid(trk_valid),
    .bin(bus.fft_out_bin), .mag(bus.fft_out_mag), .peak(bus.max730), .peak_bin(bus.bin730)
  );

  ci_peak_tracker #(.W(W), .BIN_W(BIN_W), .LO(B850_LO), .HI(B850_HI)) u_pk850 (
    .clk(clk), .rst(rst), .clear(trk_clear), .valid(trk_valid),
    .bin(bus.fft_out_bin), .mag(bus.fft_out_mag), .peak(bus.max850), .peak_bin(bus.bin850)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.fft_in_valid <= 1'b0;
      bus.fft_in_data  <= '0;
      bus.fft_in_last  <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.overrun_cnt  <= '0;
    end else begin
      bus.fft_in_valid <= 1'b0;
      bus.fft_in_last  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.enable) state <= COLLECT;
        end
        COLLECT: begin
          if (bus.sample_rdy) begin
            bus.fft_in_valid <= 1'b1;
            bus.fft_in_data  <= bus.sample;
            cnt              <= cnt + 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
              bus.fft_in_last <= 1'b1;
              state           <= WAIT_FFT;
            end
          end
        end
        WAIT_FFT: begin
          if (bus.fft_out_valid && bus.fft_out_last) begin
            bus.res_valid <= 1'b1;
            state         <= REPORT;
          end
        end
        REPORT: begin
          if (bus.res_ack) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Samples arriving while the FFT owns the frame are lost; count them, saturating.
      if (bus.sample_rdy && busy && (bus.overrun_cnt != '1))
        bus.overrun_cnt <= bus.overrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ci_frame_sequencer.sv
// Scoreboard bench: forwarded samples and window peaks are queued at drive time and checked on DUT output.
module tb_ci_frame_sequencer;
  import ci_dsp_pkg::*;

  typedef struct packed {
    logic [11:0] m730;
    logic [5:0]  b730;
    logic [11:0] m850;
    logic [5:0]  b850;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ci_frame_sequencer_if #(.W(12), .BIN_W(6), .OVR_W(8)) bus ();
  ci_frame_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ovr_exp = 0;
  logic [12:0] exp_q[$];
  res_t        res_q[$];
  logic [11:0] mag_tbl[64];
  res_t        cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forwarded-sample scoreboard.
  always @(negedge clk) begin
    if (bus.fft_in_valid) begin
      if (exp_q.size() == 0) chk("fft_in_unexpected", 1, 0);
      else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("fft_in_data", 32'(bus.fft_in_data), 32'(e[11:0]));
        chk("fft_in_last", 32'(bus.fft_in_last), 32'(e[12]));
      end
    end
  end

  task automatic send_frame(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [11:0] v;
      v = rnd ? 12'($urandom_range(0, 4095)) : 12'(i);
      tick();
      bus.sample_rdy = 1'b1;
      bus.sample     = v;
      exp_q.push_back({(i == 63), v});
      tick();
      bus.sample_rdy = 1'b0;
    end
  endtask

  task automatic drops(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.sample_rdy = 1'b1;
      bus.sample     = 12'hABC;
      ovr_exp        = (ovr_exp < 255) ? ovr_exp + 1 : 255;
    end
    tick();
    bus.sample_rdy = 1'b0;
  endtask

  task automatic send_bins(input res_t exp);
    res_q.push_back(exp);
    for (int b = 0; b < 64; b++) begin
      tick();
      bus.fft_out_valid = 1'b1;
      bus.fft_out_bin   = 6'(b);
      bus.fft_out_mag   = mag_tbl[b];
      bus.fft_out_last  = (b == 63);
    end
    tick();
    bus.fft_out_valid = 1'b0;
    bus.fft_out_last  = 1'b0;
  endtask

  task automatic wait_res();
    int i;
    i = 0;
    @(negedge clk);
    while (!bus.res_valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("res_valid_seen", 32'(bus.res_valid), 1);
    if (res_q.size() != 0) begin
      cur = res_q.pop_front();
      chk("max730", 32'(bus.max730), 32'(cur.m730));
      chk("bin730", 32'(bus.bin730), 32'(cur.b730));
      chk("max850", 32'(bus.max850), 32'(cur.m850));
      chk("bin850", 32'(bus.bin850), 32'(cur.b850));
    end else chk("res_queue", 0, 1);
  endtask

  task automatic ack(input bit with_sample);
    tick();
    bus.res_ack    = 1'b1;
    bus.sample_rdy = with_sample;
    if (with_sample) ovr_exp = (ovr_exp < 255) ? ovr_exp + 1 : 255;
    tick();
    bus.res_ack    = 1'b0;
    bus.sample_rdy = 1'b0;
    @(negedge clk);
    chk("res_valid_after_ack", 32'(bus.res_valid), 0);
    chk("max730_cleared", 32'(bus.max730), 0);
    chk("overrun_after_ack", 32'(bus.overrun_cnt), 32'(ovr_exp));
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_fft_in_valid"}, 32'(bus.fft_in_valid), 0);
    chk({tag, "_fft_in_last"}, 32'(bus.fft_in_last), 0);
    chk({tag, "_fft_in_data"}, 32'(bus.fft_in_data), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_max"}, 32'({bus.max730, bus.max850}), 0);
    chk({tag, "_bin"}, 32'({bus.bin730, bus.bin850}), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun_cnt), 0);
  endtask

  initial begin
    bus.enable = 1'b0; bus.sample_rdy = 1'b0; bus.sample = '0;
    bus.fft_out_valid = 1'b0; bus.fft_out_bin = '0; bus.fft_out_mag = '0;
    bus.fft_out_last = 1'b0; bus.res_ack = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    tick();
    rst = 1'b0;
    bus.enable = 1'b1;

    // Frame 1: ramp samples, overruns in WAIT_FFT and REPORT, long hold, ack with a colliding sample.
    send_frame(64, 1'b0);
    drops(10);
    @(negedge clk);
    chk("overrun_wait_fft", 32'(bus.overrun_cnt), 10);
    for (int b = 0; b < 64; b++) mag_tbl[b] = 12'(b);
    mag_tbl[6] = 12'd900; mag_tbl[11] = 12'd700;
    send_bins('{m730: 12'd900, b730: 6'd6, m850: 12'd700, b850: 6'd11});
    wait_res();
    drops(3);
    @(negedge clk);
    chk("overrun_report", 32'(bus.overrun_cnt), 13);
    repeat (20) tick();
    @(negedge clk);
    chk("hold_res_valid", 32'(bus.res_valid), 1);
    chk("hold_max730", 32'(bus.max730), 32'(cur.m730));
    chk("hold_bin850", 32'(bus.bin850), 32'(cur.b850));
    ack(1'b1);

    // Frame 2: ties in the 730 window, empty 850 window, loud bins outside both, stray FFT output in COLLECT.
    tick();
    bus.fft_out_valid = 1'b1; bus.fft_out_bin = 6'd6; bus.fft_out_mag = 12'd4000;
    tick();
    bus.fft_out_valid = 1'b0;
    send_frame(64, 1'b1);
    for (int b = 0; b < 64; b++) mag_tbl[b] = '0;
    mag_tbl[5] = 12'd400; mag_tbl[6] = 12'd400; mag_tbl[7] = 12'd400;
    mag_tbl[0] = 12'd4095; mag_tbl[4] = 12'd4095; mag_tbl[8] = 12'd4095;
    mag_tbl[9] = 12'd4095; mag_tbl[13] = 12'd4095; mag_tbl[63] = 12'd4095;
    send_bins('{m730: 12'd400, b730: 6'd5, m850: 12'd0, b850: 6'd0});
    wait_res();
    ack(1'b0);

    // Frame 3: overrun saturation, descending magnitudes.
    send_frame(64, 1'b1);
    drops(300);
    @(negedge clk);
    chk("overrun_saturated", 32'(bus.overrun_cnt), 255);
    for (int b = 0; b < 64; b++) mag_tbl[b] = 12'(63 - b);
    send_bins('{m730: 12'd58, b730: 6'd5, m850: 12'd53, b850: 6'd10});
    wait_res();
    ack(1'b0);

    // Frame 4: reset part way through, then a clean frame; enable drops mid-frame.
    send_frame(30, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_zero("midreset");
    ovr_exp = 0;
    rst = 1'b0;
    send_frame(32, 1'b1);
    bus.enable = 1'b0;
    for (int i = 32; i < 64; i++) begin
      logic [11:0] v;
      v = 12'($urandom_range(0, 4095));
      tick();
      bus.sample_rdy = 1'b1;
      bus.sample     = v;
      exp_q.push_back({(i == 63), v});
      tick();
      bus.sample_rdy = 1'b0;
    end
    for (int b = 0; b < 64; b++) mag_tbl[b] = 12'(b);
    send_bins('{m730: 12'd7, b730: 6'd7, m850: 12'd12, b850: 6'd12});
    wait_res();
    ack(1'b0);

    // Idle with enable low: samples neither forwarded nor counted.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.sample_rdy = 1'b1;
      tick();
      bus.sample_rdy = 1'b0;
    end
    repeat (2) tick();
    @(negedge clk);
    chk("idle_no_overrun", 32'(bus.overrun_cnt), 0);
    chk("fwd_queue_empty", 32'(exp_q.size()), 0);
    chk("res_queue_empty", 32'(res_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
